// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the load/store unit: size codes, load pipeline
// metadata and byte-lane decoding.
package mem_lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Metadata carried by each load pipeline stage; the tag travels alongside.
  typedef struct packed {
    logic       valid;
    logic       fault;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] off;
  } lsu_meta_t;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] off);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << off;
      SIZE_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default:   lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = off[0];
      default:   is_misaligned = (off != 2'b00);
    endcase
  endfunction

  // Drops the offset bits that would make the access straddle its natural boundary.
  function automatic logic [1:0] aligned_off(input logic [1:0] size,
                                             input logic [1:0] off);
    case (size)
      SIZE_BYTE: aligned_off = off;
      SIZE_HALF: aligned_off = {off[1], 1'b0};
      default:   aligned_off = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data extraction: shift the returned word down to the
// requested byte offset, then sign- or zero-extend byte/half results.
module lsu_load_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    case (size_i)
      SIZE_BYTE: data_o = {{24{sgn_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data_o = {{16{sgn_i & shifted[15]}}, shifted[15:0]};
      default:   data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of the unified mem block: byte-lane store encoding
// and a 3-stage load tracker. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_fault
);

  // Handshake: neither side has a ready. A request with req_valid=1 is taken
  // on any clk_en=1 edge; resp_valid is a one-enabled-cycle pulse that simply
  // holds its value while clk_en=0, exactly like the mem block it tracks.

  logic [1:0]        size_n;
  logic [1:0]        off_eff;
  logic              fault_req;
  logic [ADDR_W-1:0] word_addr;

  assign size_n    = (req_size == 2'd3) ? SIZE_WORD : req_size;
  assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};
  assign mem_raddr = word_addr;
  assign mem_waddr = word_addr;

`ifdef MISALIGN_TRAP_EN
  assign off_eff   = req_addr[1:0];
  assign fault_req = is_misaligned(size_n, req_addr[1:0]);
`else
  assign off_eff   = aligned_off(size_n, req_addr[1:0]);
  assign fault_req = 1'b0;
`endif

  always_comb begin
    mem_wen = 4'b0000;
    if (req_valid && req_store && clk_en && !rst && !fault_req) begin
      mem_wen = lane_mask(size_n, off_eff);
    end
  end

  // Replicated data lets mem pick any lane purely from the write enables.
  always_comb begin
    case (size_n)
      SIZE_BYTE: mem_wdata = {4{req_wdata[7:0]}};
      SIZE_HALF: mem_wdata = {2{req_wdata[15:0]}};
      default:   mem_wdata = req_wdata;
    endcase
  end

  lsu_meta_t        s1_d, s1_q, s2_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
  logic [31:0]      align_data;

  logic             resp_valid_d, resp_valid_q;
  logic [31:0]      resp_data_d, resp_data_q;
  logic [TAG_W-1:0] resp_tag_d, resp_tag_q;
  logic             resp_fault_d, resp_fault_q;

  // Good stores never enter the pipeline; trapped stores must, to report the fault.
  always_comb begin
    s1_d       = '0;
    s1_d.valid = req_valid & (~req_store | fault_req);
    s1_d.fault = fault_req;
    s1_d.size  = size_n;
    s1_d.sgn   = req_signed;
    s1_d.off   = off_eff;
  end

  lsu_load_align u_align (
    .rdata_i (mem_rdata),
    .size_i  (s2_q.size),
    .sgn_i   (s2_q.sgn),
    .off_i   (s2_q.off),
    .data_o  (align_data)
  );

  always_comb begin
    resp_valid_d = s2_q.valid;
    resp_data_d  = (s2_q.valid && !s2_q.fault) ? align_data : 32'd0;
    resp_tag_d   = s2_q.valid ? s2_tag_q : '0;
    resp_fault_d = s2_q.valid & s2_q.fault;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      s1_tag_q     <= '0;
      s2_tag_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_tag_q   <= '0;
      resp_fault_q <= 1'b0;
    end else if (clk_en) begin
      s1_q         <= s1_d;
      s1_tag_q     <= req_tag;
      s2_q         <= s1_q;
      s2_tag_q     <= s1_tag_q;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a 2-cycle mem model, a byte-array reference memory and
// an expected-response queue keyed on enabled-cycle count.
module tb_mem_lsu;

  localparam int ADDR_W = 18;
  localparam int TAG_W  = 5;
  localparam int EXP_W  = 70;

  logic              clk = 1'b0;
  logic              rst, clk_en;
  logic              req_valid, req_store, req_signed;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [TAG_W-1:0]  req_tag;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;
  logic [3:0]        mem_wen;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              resp_valid, resp_fault;
  logic [31:0]       resp_data;
  logic [TAG_W-1:0]  resp_tag;

  int checks = 0;
  int errors = 0;
  int en_count = 0;

  logic [7:0]       ref_mem [0:4095];
  logic [EXP_W-1:0] exp_q[$];
  logic             ovr_en = 1'b0;
  logic [31:0]      ovr_data = 32'd0;

  // clock/reset block
  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .req_valid(req_valid), .req_store(req_store), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_tag(req_tag), .mem_raddr(mem_raddr), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag),
    .resp_fault(resp_fault)
  );

  // Environment: mem with 2-cycle read latency, frozen with clk_en.
  logic [31:0] env_mem [0:1023];
  logic [31:0] rd1_q = 32'd0, rd2_q = 32'd0;
  assign mem_rdata = rd2_q;

  always @(posedge clk) begin
    if (clk_en) begin
      for (int k = 0; k < 4; k++)
        if (mem_wen[k]) env_mem[mem_waddr[11:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
      rd1_q <= env_mem[mem_raddr[11:2]];
      rd2_q <= rd1_q;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  // Reference model of one accepted request, evaluated on whole bytes.
  task automatic model_issue();
    int n, a;
    logic [31:0] v;
    n = nbytes(req_size);
    a = int'(req_addr);
`ifdef MISALIGN_TRAP_EN
    if ((a % n) != 0) begin
      exp_q.push_back({32'(en_count + 3), 1'b1, req_tag, 32'd0});
      return;
    end
`else
    a = a - (a % n);
`endif
    if (req_store) begin
      for (int i = 0; i < n; i++) ref_mem[a + i] = req_wdata[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
      if (req_signed && n < 4 && v[8*n-1])
        for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      if (ovr_en) v = ovr_data;
      exp_q.push_back({32'(en_count + 3), 1'b0, req_tag, v});
    end
  endtask

  task automatic check_outputs();
    int n, a, base;
    logic [3:0] exp_wen;
    logic [31:0] exp_lanes, mask;
    logic exp_v;
    logic skip;
    chk("mem_raddr", 32'(mem_raddr), 32'(req_addr & ~18'd3));
    chk("mem_waddr", 32'(mem_waddr), 32'(req_addr & ~18'd3));
    exp_wen = 4'd0; exp_lanes = 32'd0; mask = 32'd0; skip = 1'b0;
    if (!rst && clk_en && req_valid && req_store) begin
      n = nbytes(req_size);
      a = int'(req_addr);
`ifdef MISALIGN_TRAP_EN
      skip = ((a % n) != 0);
`else
      a = a - (a % n);
`endif
      base = a % 4;
      if (!skip)
        for (int i = 0; i < n; i++) begin
          exp_wen[base + i] = 1'b1;
          exp_lanes[8*(base+i) +: 8] = req_wdata[8*i +: 8];
          mask[8*(base+i) +: 8] = 8'hFF;
        end
    end
    chk("mem_wen", 32'(mem_wen), 32'(exp_wen));
    if (exp_wen != 4'd0) chk("mem_wdata_lanes", mem_wdata & mask, exp_lanes);

    while (exp_q.size() > 0 && int'(exp_q[0][69:38]) < en_count) void'(exp_q.pop_front());
    exp_v = (exp_q.size() > 0) && (int'(exp_q[0][69:38]) == en_count);
    chk("resp_valid", 32'(resp_valid), 32'(exp_v));
    if (exp_v) begin
      chk("resp_data", resp_data, exp_q[0][31:0]);
      chk("resp_tag", 32'(resp_tag), 32'(exp_q[0][36:32]));
      chk("resp_fault", 32'(resp_fault), 32'(exp_q[0][37]));
    end
  endtask

  // One clock: check mid-cycle, record acceptance, then advance past the edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    if (!rst && clk_en && req_valid) model_issue();
    @(posedge clk);
    if (rst) exp_q.delete();
    else if (clk_en) en_count++;
    #1;
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic st, input logic [1:0] sz,
                       input logic sg, input logic [ADDR_W-1:0] ad,
                       input logic [31:0] wd, input logic [TAG_W-1:0] tg);
    req_valid = v; req_store = st; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd; req_tag = tg;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      drive(1'b0, 1'b0, 2'd0, 1'b0, '0, 32'd0, '0);
      cycle();
    end
  endtask

  task automatic load_exp(input logic [ADDR_W-1:0] ad, input logic [1:0] sz,
                          input logic sg, input logic [TAG_W-1:0] tg,
                          input logic [31:0] exp);
    drive(1'b1, 1'b0, sz, sg, ad, 32'd0, tg);
    ovr_en = 1'b1; ovr_data = exp;
    cycle();
    ovr_en = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_data"}, resp_data, 32'd0);
    chk({tag, "_tag"}, 32'(resp_tag), 32'd0);
    chk({tag, "_fault"}, 32'(resp_fault), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++)
      env_mem[i] = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
    rst = 1'b1; clk_en = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 1'b0, '0, 32'd0, '0);
    @(posedge clk); #1;
    idle(2);
    rst = 1'b0;
    check_zero_outputs("reset");

    // byte store replication and lane select
    drive(1'b1, 1'b1, 2'd0, 1'b0, 18'h00003, 32'h000000A5, '0);
    #1;
    chk("store_byte_wen", 32'(mem_wen), 32'h8);
    chk("store_byte_wdata", mem_wdata, 32'hA5A5A5A5);
    cycle();
    drive(1'b1, 1'b0, 2'd2, 1'b0, 18'h00000, 32'd0, 5'd7);
    cycle();
    idle(4);

    // extraction with sign/zero extension
    drive(1'b1, 1'b1, 2'd2, 1'b0, 18'h00010, 32'h80FF7F01, '0);
    cycle();
    load_exp(18'h00011, 2'd0, 1'b1, 5'd4, 32'h0000007F);
    load_exp(18'h00013, 2'd0, 1'b1, 5'd5, 32'hFFFFFF80);
    load_exp(18'h00012, 2'd1, 1'b0, 5'd6, 32'h000080FF);
    idle(4);

    // back-to-back loads stalled mid-flight; requests during the stall are ignored
    drive(1'b1, 1'b0, 2'd2, 1'b0, 18'h00010, 32'd0, 5'd1); cycle();
    drive(1'b1, 1'b0, 2'd0, 1'b0, 18'h00011, 32'd0, 5'd2); cycle();
    drive(1'b1, 1'b0, 2'd1, 1'b1, 18'h00012, 32'd0, 5'd3); cycle();
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i[0], 2'd0, 1'b0, 18'h00014, 32'h12345678, 5'd9);
      cycle();
    end
    clk_en = 1'b1;
    idle(5);

    // store then immediate load of the same word
    drive(1'b1, 1'b1, 2'd2, 1'b0, 18'h00020, 32'hDEADBEEF, '0); cycle();
    load_exp(18'h00020, 2'd2, 1'b0, 5'd8, 32'hDEADBEEF);
    idle(4);

    // reset with loads in flight, store request held during reset
    drive(1'b1, 1'b0, 2'd2, 1'b0, 18'h00020, 32'd0, 5'd10); cycle();
    drive(1'b1, 1'b0, 2'd2, 1'b0, 18'h00024, 32'd0, 5'd11); cycle();
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'd2, 1'b0, 18'h00028, 32'hCAFEF00D, '0);
    #1;
    chk("wen_in_reset", 32'(mem_wen), 32'd0);
    cycle();
    clk_en = 1'b0;
    cycle();
    clk_en = 1'b1;
    rst = 1'b0;
    check_zero_outputs("post_reset");
    idle(5);

    // misaligned word load
    drive(1'b1, 1'b0, 2'd2, 1'b0, 18'h00006, 32'd0, 5'd12); cycle();
    drive(1'b1, 1'b1, 2'd1, 1'b0, 18'h00031, 32'h0000BEEF, 5'd13); cycle();
    idle(4);

    // randomized traffic with random stalls
    for (int i = 0; i < 400; i++) begin
      clk_en = ($urandom_range(0, 99) < 85);
      drive($urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            18'($urandom_range(0, 255)), $urandom, 5'($urandom_range(0, 31)));
      cycle();
    end
    clk_en = 1'b1;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit sitting directly upstream of the pipeline's unified `mem` block. It drives `mem` read port 1 and the byte-enable write port, and consumes `rdata1`.
- Converts byte/half/word requests into word addresses plus byte-lane enables, with replicated store data.
- Tracks each load through `mem`'s 2-cycle read latency, then aligns and sign- or zero-extends the returned word into a tagged writeback response.

Parameters:
- ADDR_W, 18, byte-address width; matches the `mem` address ports.
- TAG_W, 5, destination-register tag carried alongside each load.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clk_en  in  1  global stall; shared with `mem`, so both freeze together when low
- req_valid  in  1  request present this cycle; always accepted when clk_en=1 (no backpressure)
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word)
- req_signed  in  1  load sign-extends when 1
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- req_tag  in  TAG_W  load destination tag
- mem_raddr  out  ADDR_W  to `mem` raddr1
- mem_wen  out  4  to `mem` wen
- mem_waddr  out  ADDR_W  to `mem` waddr
- mem_wdata  out  32  to `mem` wdata
- mem_rdata  in  32  from `mem` rdata1
- resp_valid  out  1  load result valid
- resp_data  out  32  aligned, extended load data
- resp_tag  out  TAG_W  tag of the completed load
- resp_fault  out  1  misaligned access (only with MISALIGN_TRAP_EN)

Behaviour:
- Memory-side outputs are combinational from req_*:
  - mem_raddr = mem_waddr = {req_addr[ADDR_W-1:2], 2'b00}.
  - mem_wen = 0 unless req_valid & req_store & clk_en & !rst.
- Byte lanes are little-endian, lane k = bits [8k+7:8k]. off = req_addr[1:0].
  - byte: wen = 1<<off; wdata = byte replicated 4x.
  - half: wen = 4'b0011 when off[1]=0, else 4'b1100; wdata = half replicated 2x.
  - word: wen = 4'b1111; wdata unchanged.
- Load pipeline, 3 registers: s1 (issue), s2 (mem internal), out.
  - Each of s1/s2 holds {valid, size, signed, off, tag}.
  - All advance only when clk_en=1; the whole pipeline holds when clk_en=0.
- Latency: a load accepted in cycle N gives resp_valid=1 in cycle N+3, for exactly one enabled cycle.
  - mem_rdata is valid while the load sits in s2. Extraction is combinational from mem_rdata and s2 metadata, registered into out.
- Extraction: shift mem_rdata right by 8*off; byte/half take the low 8/16 bits, then sign- or zero-extend per s2.signed. Word passes through.
- Stores produce no response and do not occupy s1/s2.
- Back-to-back loads are accepted every cycle, giving up to 3 in flight. Responses emerge in order.
- A store in cycle N followed by a load to the same word in N+1 returns the new data (`mem` commits the write at the end of cycle N). No forwarding logic is required.
- Reset (synchronous, rst=1 at a clk edge):
  - s1/s2/out valid cleared; resp_valid=0, resp_data=0, resp_tag=0, resp_fault=0.
  - In-flight loads are discarded, and mem_wen is forced to 0 during rst.
  - Reset takes effect even when clk_en=0.
- Misalignment (half with off[0]=1, or word with off≠0) is handled per the optional feature below.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - A misaligned request suppresses mem_wen.
  - It enters the pipeline as a fault entry and produces resp_valid=1, resp_fault=1, resp_data=0 at N+3, using req_tag. This applies to stores as well.
- Undefined:
  - resp_fault is tied to 0.
  - Offending low address bits are masked: half uses off&2'b10, word uses 2'b00. The access proceeds aligned.

Decomposition:
- Package mem_lsu_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants;
  - the pipeline-entry struct typedef;
  - a lane-mask function.
- One sub-module, lsu_load_align: purely combinational shift/extend from (rdata, size, signed, off) to data. It is reused by the decode stage's test model.

Test Plan:
- Store byte 0xA5 at addr 0x0003 → mem_wen=4'b1000, mem_waddr=0x0000, mem_wdata=0xA5A5A5A5; a later word load returns 0xA5xxxxxx.
- Memory word 0x80FF7F01 at 0x0010; signed byte load at 0x0011 → resp_data=0x0000007F; signed byte at 0x0013 → 0xFFFFFF80; unsigned half at 0x0012 → 0x000080FF. Each resp_valid arrives exactly 3 cycles after issue, with tags preserved.
- Three back-to-back loads with tags 1, 2, 3, then clk_en=0 for 4 cycles mid-flight → responses emerge in order 1, 2, 3 with no loss or duplication, and resp_valid is held during the stall.
- Store word 0xDEADBEEF to 0x0020, then a load of 0x0020 in the next cycle → resp_data=0xDEADBEEF.
- rst asserted with 2 loads in flight → no resp_valid afterwards, all outputs 0, mem_wen=0 during reset.
- Word load at 0x0006:
  - with MISALIGN_TRAP_EN → resp_fault=1, resp_data=0;
  - without it → data of word 0x0004.
